arm_control_unit: RTL and testbench
===================================

# arm_control_unit

Control unit of the single-cycle ARM-subset processor. It decodes the instruction fields (Op, Funct, Rd, Cond) into datapath controls: main decode, ALU decode and PC-write logic. It also holds the NZCV condition-flag register and gates every architectural write with the condition check. It sits between the instruction memory output and the datapath.

## Interface
Parameters: none.

Clocking and reset (decided): one clock; reset is asynchronous and active-high.

- clk  in  1  rising-edge clock for the flag register
- reset  in  1  asynchronous, active-high; clears the flag register
- Cond  in  4  instruction bits [31:28], the condition code
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S (L for memory ops)
- Rd  in  4  instruction bits [15:12]
- ALUFlags  in  4  current ALU result flags {N,Z,C,V}
- PCSrc  out  1  select ALU result as next PC
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  data-memory write enable
- MemtoReg  out  1  writeback source is memory
- ALUSrc  out  1  ALU operand B is the extended immediate
- ImmSrc  out  2  immediate format: 00 imm8, 01 imm12, 10 imm24 branch
- RegSrc  out  2  [0]=RA1 is PC (R15); [1]=RA2 is Rd
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
**Main decode** (internal outputs Branch, MemtoReg, MemW, ALUSrc, ImmSrc, RegW, RegSrc, ALUOp):
- Op=00, I=0 (data-processing, register): RegW=1, ALUOp=1; all others 0.
- Op=00, I=1 (data-processing, immediate): RegW=1, ALUOp=1, ALUSrc=1, ImmSrc=00.
- Op=01, L=0 (STR): MemW=1, ALUSrc=1, ImmSrc=01, RegSrc=10, RegW=0.
- Op=01, L=1 (LDR): MemtoReg=1, RegW=1, ALUSrc=1, ImmSrc=01, RegSrc=00.
- Op=10 (B): Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, RegW=0.
- Op=11: all controls 0.
- Every don't-care in the rows above is driven as 0.

**ALU decode**:
- ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
- ALUOp=1, by cmd:
  - 0100 ADD → 00
  - 0010 SUB → 01
  - 0000 AND → 10
  - 1100 ORR → 11
  - 1010 CMP → 01, NoWrite=1, FlagW=11 regardless of S.
  - Any other cmd: ALUControl=00, NoWrite=1, FlagW=00.
- For ADD/SUB/AND/ORR:
  - FlagW[1] (NZ) = S.
  - FlagW[0] (CV) = S when ALUControl is 00 or 01; otherwise 0.

**PC logic**: PCS = Branch | (RegW & Rd==4'hF). This uses the ungated RegW from main decode.

**Condition check** (CondEx), evaluated on the *registered* flags {N,Z,C,V}, not on ALUFlags:

| Cond | Mnemonic | CondEx |
|---|---|---|
| 0000 | EQ | Z |
| 0001 | NE | ~Z |
| 0010 | CS | C |
| 0011 | CC | ~C |
| 0100 | MI | N |
| 0101 | PL | ~N |
| 0110 | VS | V |
| 0111 | VC | ~V |
| 1000 | HI | C&~Z |
| 1001 | LS | ~(C&~Z) |
| 1010 | GE | N==V |
| 1011 | LT | N!=V |
| 1100 | GT | ~Z&(N==V) |
| 1101 | LE | Z\|(N!=V) |
| 1110 | AL | 1 |
| 1111 | — | 0 |

**Gating**:
- PCSrc = PCS & CondEx
- RegWrite = RegW & CondEx & ~NoWrite
- MemWrite = MemW & CondEx
- FlagWrite = FlagW & {2{CondEx}}
- MemtoReg, ALUSrc, ImmSrc, RegSrc and ALUControl are not gated.

## Timing
- All outputs are purely combinational from the inputs and the flag register, valid in the same cycle. There are no pipeline stages.
- Flag register update on the rising clk edge:
  - FlagWrite[1] loads N,Z from ALUFlags[3:2].
  - FlagWrite[0] loads C,V from ALUFlags[1:0].
  - The two halves update independently. Bits whose enable is low hold their value.
- Reset asserts asynchronously and clears all flags to 0000 immediately, including during an active flag write; reset wins. Consequences after reset:
  - EQ, CS, MI, VS, HI, LT and LE evaluate 0.
  - NE, CC, PL, VC, LS, GE, GT and AL evaluate 1.
- A flag write takes effect for the next instruction only. The instruction that writes the flags is conditioned on the old flags.

## Structure
- A shared package holds:
  - Op encodings (DP=00, MEM=01, BR=10)
  - cmd encodings (AND, SUB, ADD, CMP, ORR)
  - condition-code constants
  - ALUControl codes
  - ImmSrc codes
- Main decode, ALU decode and PC logic are flat combinational logic in the top.
- One sub-module, cond_logic, holds the flag register, the CondEx evaluation and the write gating.

## Test plan
- Reset, then Cond=0000 (EQ) with ADD register form, Rd=1 → RegWrite=0. Same instruction with Cond=1110 → RegWrite=1, ALUControl=00, ALUSrc=0.
- SUBS (Op=00, Funct=100101), Cond=AL, ALUFlags=0100, clock edge → flags=0100. The next EQ instruction gets CondEx=1.
- CMP (Funct=010101), Cond=AL, ALUFlags=1001, clock edge → RegWrite=0, ALUControl=01, flags become 1001. GE now evaluates 1 and LT evaluates 0.
- ANDS with ALUFlags=1111 → only NZ update: flags=11 followed by the previously held CV bits.
- STR (Op=01, Funct=011000) → MemWrite=1, RegWrite=0, ImmSrc=01, RegSrc=10. LDR (Funct=011001) → MemtoReg=1, RegWrite=1.
- B (Op=10), Cond=AL → PCSrc=1, ImmSrc=10, RegSrc=01. ADD with Rd=15, Cond=AL → PCSrc=1, RegWrite=1. Assert reset mid-test → flags read 0000 before the next clock edge.

Source files
------------

// File: rtl/arm_control_unit_pkg.sv
// Shared encodings for the ARM-subset control unit: instruction Op classes,
// data-processing cmd codes, condition codes, ALUControl and ImmSrc codes.
package arm_control_unit_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM8  = 2'b00,
    IMM12 = 2'b01,
    IMM24 = 2'b10
  } imm_src_e;

endpackage

// File: rtl/arm_control_unit_if.sv
// Instruction-field / datapath-control bundle of the control unit.
// slave  : the control unit (takes instruction fields + ALU flags, drives controls)
// master : the datapath / instruction memory side
interface arm_control_unit_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemtoReg;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl
  );

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/arm_control_unit_cond_logic.sv
// NZCV flag register, condition evaluation and gating of architectural writes.
// Ports: clk/reset (async, active-high, clears flags); cond, alu_flags {N,Z,C,V};
// ungated flag_w, pcs, reg_w, no_write, mem_w from decode; gated pc_src,
// reg_write, mem_write out.
module arm_control_unit_cond_logic
  import arm_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       no_write,
  input  logic       mem_w,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;
  logic       cond_ex;
  logic [1:0] flag_write;

  assign {n, z, c, v} = flags_q;

  // Condition is judged on the registered flags, so a flag-setting
  // instruction is itself conditioned on the previous flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~(c & ~z);
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = flag_w & {2{cond_ex}};
  assign pc_src     = pcs & cond_ex;
  assign reg_write  = reg_w & cond_ex & ~no_write;
  assign mem_write  = mem_w & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
    if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_control_unit.sv
// Control unit of the single-cycle ARM-subset processor: main decode, ALU
// decode and PC-write logic, with condition gating in the cond_logic block.
// Ports: clk, reset (async, active-high); bus (slave) carries Cond/Op/Funct/Rd/
// ALUFlags in and PCSrc/RegWrite/MemWrite/MemtoReg/ALUSrc/ImmSrc/RegSrc/
// ALUControl out. All outputs are combinational in the same cycle.
module arm_control_unit
  import arm_control_unit_pkg::*;
(
  input logic               clk,
  input logic               reset,
  arm_control_unit_if.slave bus
);

  logic       branch, mem_to_reg, mem_w, alu_src, reg_w, alu_op;
  imm_src_e   imm_src;
  logic [1:0] reg_src;
  alu_ctrl_e  alu_control;
  logic [1:0] flag_w;
  logic       no_write;
  logic       pcs;
  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = bus.Funct[4:1];
  assign s_bit = bus.Funct[0];

  // Main decode
  always_comb begin
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    mem_w      = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM8;
    reg_w      = 1'b0;
    reg_src    = 2'b00;
    alu_op     = 1'b0;
    case (bus.Op)
      OP_DP: begin
        reg_w   = 1'b1;
        alu_op  = 1'b1;
        alu_src = bus.Funct[5];
      end
      OP_MEM: begin
        alu_src = 1'b1;
        imm_src = IMM12;
        if (bus.Funct[0]) begin
          mem_to_reg = 1'b1;
          reg_w      = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM24;
        reg_src = 2'b01;
      end
      default: ;
    endcase
  end

  // ALU decode
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = {s_bit, s_bit}; end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = {s_bit, s_bit}; end
        CMD_AND: begin alu_control = ALU_AND; flag_w = {s_bit, 1'b0};  end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = {s_bit, 1'b0};  end
        CMD_CMP: begin alu_control = ALU_SUB; flag_w = 2'b11; no_write = 1'b1; end
        default: no_write = 1'b1;
      endcase
    end
  end

  // Uses ungated reg_w: a CMP with Rd=15 still drives PCS.
  assign pcs = branch | (reg_w & (bus.Rd == 4'hF));

  arm_control_unit_cond_logic u_cond_logic (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .no_write  (no_write),
    .mem_w     (mem_w),
    .pc_src    (bus.PCSrc),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite)
  );

  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrc     = alu_src;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegSrc     = reg_src;
  assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_arm_control_unit.sv
// Bench for arm_control_unit: instruction-level model of the control unit
// with its own NZCV register, compared every cycle, plus literal expectations.
module tb_arm_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arm_control_unit_if bus ();

  arm_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [3:0] m_flags = 4'b0000; // {N,Z,C,V}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected vector: {PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl}
  task automatic model_eval(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] rd, input logic [3:0] fl,
                            output logic [12:0] e, output logic [1:0] fw);
    logic ce, pcsrc, regwr, memwr, m2r, asrc, s, known, arith;
    logic [1:0] imm, rsrc, aluc;
    logic [3:0] cmd;
    ce = cond_ok(c, fl);
    pcsrc = 0; regwr = 0; memwr = 0; m2r = 0; asrc = 0;
    imm = 2'b00; rsrc = 2'b00; aluc = 2'b00; fw = 2'b00;
    cmd = f[4:1];
    s = f[0];
    if (o == 2'b00) begin
      known = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
      arith = (cmd == 4'd4) || (cmd == 4'd2);
      case (cmd)
        4'd2, 4'd10: aluc = 2'b01;
        4'd0:        aluc = 2'b10;
        4'd12:       aluc = 2'b11;
        default:     aluc = 2'b00;
      endcase
      if (cmd == 4'd10) fw = 2'b11;
      else if (known)   fw = {s, s & arith};
      regwr = known & ce;
      pcsrc = (rd == 4'hF) & ce;
      asrc = f[5];
    end else if (o == 2'b01) begin
      asrc = 1; imm = 2'b01;
      m2r = f[0];
      rsrc = f[0] ? 2'b00 : 2'b10;
      regwr = f[0] & ce;
      memwr = !f[0] & ce;
      pcsrc = f[0] & (rd == 4'hF) & ce;
    end else if (o == 2'b10) begin
      pcsrc = ce; asrc = 1; imm = 2'b10; rsrc = 2'b01;
    end
    fw = fw & {2{ce}};
    e = {pcsrc, regwr, memwr, m2r, asrc, imm, rsrc, aluc};
  endtask

  function automatic logic [12:0] dut_vec();
    return {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.MemtoReg, bus.ALUSrc,
            bus.ImmSrc, bus.RegSrc, bus.ALUControl};
  endfunction

  // Model flag register
  always @(posedge clk or posedge reset) begin
    logic [12:0] e;
    logic [1:0] fw;
    if (reset) m_flags = 4'b0000;
    else begin
      model_eval(bus.Cond, bus.Op, bus.Funct, bus.Rd, m_flags, e, fw);
      if (fw[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (fw[0]) m_flags[1:0] = bus.ALUFlags[1:0];
    end
  end

  // Per-cycle compare, 2 time units after the stimulus edge
  always @(negedge clk) begin
    logic [12:0] e;
    logic [1:0] fw;
    if (chk_en) begin
      #2;
      model_eval(bus.Cond, bus.Op, bus.Funct, bus.Rd, m_flags, e, fw);
      check("cycle_outputs", {19'd0, dut_vec()}, {19'd0, e});
    end
  end

  task automatic apply(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af);
    @(negedge clk);
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
  endtask

  localparam logic [5:0] F_ADD  = 6'b001000;
  localparam logic [5:0] F_SUBS = 6'b100101;
  localparam logic [5:0] F_CMP  = 6'b010101;
  localparam logic [5:0] F_ANDS = 6'b000001;

  initial begin
    bus.Cond = 4'h0; bus.Op = 2'b00; bus.Funct = 6'h00; bus.Rd = 4'h0; bus.ALUFlags = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset flags: EQ ADD does not write, AL ADD does
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("eq_after_reset_regwrite", bus.RegWrite, 1'b0);
    apply(4'hE, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("al_add_regwrite", bus.RegWrite, 1'b1);
    check("al_add_aluctl", bus.ALUControl, 2'b00);
    check("al_add_alusrc", bus.ALUSrc, 1'b0);

    // SUBS sets Z; next EQ passes
    apply(4'hE, 2'b00, F_SUBS, 4'd2, 4'b0100); #3;
    check("subs_aluctl", bus.ALUControl, 2'b01);
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("eq_after_subs", bus.RegWrite, 1'b1);

    // CMP loads 1001
    apply(4'hE, 2'b00, F_CMP, 4'd0, 4'b1001); #3;
    check("cmp_regwrite", bus.RegWrite, 1'b0);
    check("cmp_aluctl", bus.ALUControl, 2'b01);
    apply(4'hA, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("ge_after_cmp", bus.RegWrite, 1'b1);
    apply(4'hB, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("lt_after_cmp", bus.RegWrite, 1'b0);

    // ANDS with 1111: flags -> 1101
    apply(4'hE, 2'b00, F_ANDS, 4'd3, 4'b1111); #3;
    check("ands_aluctl", bus.ALUControl, 2'b10);
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("eq_after_ands", bus.RegWrite, 1'b1);
    apply(4'h2, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("cs_after_ands", bus.RegWrite, 1'b0);
    apply(4'h6, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("vs_after_ands", bus.RegWrite, 1'b1);

    // STR / LDR
    apply(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0); #3;
    check("str_memwrite", bus.MemWrite, 1'b1);
    check("str_regwrite", bus.RegWrite, 1'b0);
    check("str_immsrc", bus.ImmSrc, 2'b01);
    check("str_regsrc", bus.RegSrc, 2'b10);
    apply(4'hE, 2'b01, 6'b011001, 4'd4, 4'h0); #3;
    check("ldr_memtoreg", bus.MemtoReg, 1'b1);
    check("ldr_regwrite", bus.RegWrite, 1'b1);

    // Branch, PC write via Rd=15, reserved Op, unknown cmd
    apply(4'hE, 2'b10, 6'h00, 4'd0, 4'h0); #3;
    check("b_pcsrc", bus.PCSrc, 1'b1);
    check("b_immsrc", bus.ImmSrc, 2'b10);
    check("b_regsrc", bus.RegSrc, 2'b01);
    apply(4'hE, 2'b00, F_ADD, 4'hF, 4'h0); #3;
    check("add_pc_pcsrc", bus.PCSrc, 1'b1);
    check("add_pc_regwrite", bus.RegWrite, 1'b1);
    apply(4'hE, 2'b11, 6'h3F, 4'hF, 4'hF); #3;
    check("op11_all_zero", {19'd0, dut_vec()}, 32'd0);
    apply(4'hE, 2'b00, 6'b000011, 4'd1, 4'hF); #3;
    check("eor_nowrite", bus.RegWrite, 1'b0);

    // Condition sweep across several flag states loaded by CMP
    for (int k = 0; k < 6; k++) begin
      logic [3:0] fv;
      fv = 4'($urandom_range(0, 15));
      apply(4'hE, 2'b00, F_CMP, 4'd0, fv);
      for (int cc = 0; cc < 16; cc++) apply(4'(cc), 2'b00, F_ADD, 4'd1, 4'h0);
    end

    // Random instructions
    for (int k = 0; k < 300; k++)
      apply(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom));

    // Reset mid-test: set Z first, then async reset clears it before the edge
    apply(4'hE, 2'b00, F_SUBS, 4'd2, 4'b0100);
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("eq_before_reset", bus.RegWrite, 1'b1);
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0);
    #1 reset = 1'b1;
    #2;
    check("eq_during_reset", bus.RegWrite, 1'b0);
    check("ne_during_reset", 32'(dut.u_cond_logic.pc_src | bus.RegWrite), 32'd0);
    apply(4'hE, 2'b00, F_SUBS, 4'd2, 4'b1111); // reset wins over this flag write
    apply(4'h0, 2'b00, F_ADD, 4'd1, 4'h0);
    #1 reset = 1'b0;
    #2;
    check("eq_after_reset_write", bus.RegWrite, 1'b0);
    apply(4'h1, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("ne_after_reset_write", bus.RegWrite, 1'b1);
    apply(4'hC, 2'b00, F_ADD, 4'd1, 4'h0); #3;
    check("gt_after_reset_write", bus.RegWrite, 1'b1);

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
